// File: rtl/pair_match_ctrl.sv
// Pair-matching game controller for a 4x4 card board.
// Reveals two picked cells, compares them, keeps score.
module pair_match_ctrl #(
    parameter int N_CELLS     = 16,
    parameter int VAL_W       = 4,
    parameter int HIDE_CYCLES = 50
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       select,
    input  logic [$clog2(N_CELLS)-1:0] cursor,
    input  logic [N_CELLS*VAL_W-1:0]   board,
    output logic [N_CELLS-1:0]         revealed,
    output logic [N_CELLS-1:0]         matched,
    output logic [7:0]                 attempts,
    output logic [3:0]                 pairs,
    output logic                       mismatch,
    output logic                       game_over
);

    localparam int CUR_W       = $clog2(N_CELLS);
    localparam int TMR_W       = $clog2(HIDE_CYCLES + 1);
    localparam int PAIRS_TOTAL = N_CELLS / 2;

    typedef enum logic [2:0] {
        PICK1,
        PICK2,
        COMPARE,
        SHOW,
        DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               select_q;
    logic [CUR_W-1:0]   first_q;
    logic [CUR_W-1:0]   first_d;
    logic [CUR_W-1:0]   second_q;
    logic [CUR_W-1:0]   second_d;
    logic [TMR_W-1:0]   timer_q;
    logic [TMR_W-1:0]   timer_d;
    logic [N_CELLS-1:0] revealed_d;
    logic [N_CELLS-1:0] matched_d;
    logic [7:0]         attempts_d;
    logic [3:0]         pairs_d;

    logic               sel_edge;
    logic               in_range;
    logic               pick_ok;
    logic [VAL_W-1:0]   val_a;
    logic [VAL_W-1:0]   val_b;

    // A full-width cursor can only address real cells on a power-of-two board.
    if (N_CELLS == (2 ** CUR_W)) begin : g_full
        assign in_range = 1'b1;
    end else begin : g_part
        assign in_range = (32'(cursor) < 32'(N_CELLS));
    end

    assign sel_edge = select & ~select_q;
    assign pick_ok  = sel_edge & in_range
                    & ~revealed[cursor] & ~matched[cursor];

    assign val_a = board[VAL_W*first_q +: VAL_W];
    assign val_b = board[VAL_W*second_q +: VAL_W];

    assign mismatch  = (state_q == SHOW);
    assign game_over = (state_q == DONE);

    // Next-state and datapath updates for the pick/compare/show flow.
    always_comb begin
        state_d    = state_q;
        first_d    = first_q;
        second_d   = second_q;
        timer_d    = timer_q;
        revealed_d = revealed;
        matched_d  = matched;
        attempts_d = attempts;
        pairs_d    = pairs;
        unique case (state_q)
            PICK1: begin
                if (pick_ok) begin
                    revealed_d[cursor] = 1'b1;
                    first_d            = cursor;
                    state_d            = PICK2;
                end
            end
            PICK2: begin
                if (pick_ok) begin
                    revealed_d[cursor] = 1'b1;
                    second_d           = cursor;
                    state_d            = COMPARE;
                end
            end
            COMPARE: begin
                if (attempts != 8'hFF) begin
                    attempts_d = attempts + 8'd1;
                end
                if (val_a == val_b) begin
                    matched_d[first_q]  = 1'b1;
                    matched_d[second_q] = 1'b1;
                    pairs_d             = pairs + 4'd1;
                    if (pairs_d == 4'(PAIRS_TOTAL)) begin
                        state_d = DONE;
                    end else begin
                        state_d = PICK1;
                    end
                end else begin
                    timer_d = TMR_W'(HIDE_CYCLES - 1);
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (timer_q == '0) begin
                    revealed_d[first_q]  = 1'b0;
                    revealed_d[second_q] = 1'b0;
                    state_d              = PICK1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = PICK1;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PICK1;
        end else begin
            state_q <= state_d;
        end
    end

    // Score, masks, latched picks, timer and select history.
    always_ff @(posedge clk) begin
        if (rst) begin
            select_q <= 1'b0;
            first_q  <= '0;
            second_q <= '0;
            timer_q  <= '0;
            revealed <= '0;
            matched  <= '0;
            attempts <= '0;
            pairs    <= '0;
        end else begin
            select_q <= select;
            first_q  <= first_d;
            second_q <= second_d;
            timer_q  <= timer_d;
            revealed <= revealed_d;
            matched  <= matched_d;
            attempts <= attempts_d;
            pairs    <= pairs_d;
        end
    end

endmodule

// File: doc/pair_match_ctrl.md
Name: pair_match_ctrl

Overview:
- Game-logic stage directly downstream of the 4x4 cursor/board block (16 cells, 4-bit card values, move/select buttons).
- Consumes the cursor position, the select button and the 16 card values; reveals the selected cells and compares each pair of picks.
- Tracks matched cells, the attempt count and the pair count, and hides a mismatched pair after a display delay.
- Drives the reveal/matched masks used by the display stage and a game_over flag.

Parameters:
- N_CELLS, 16, number of board cells; cursor width is $clog2(N_CELLS).
- VAL_W, 4, bit width of one card value.
- HIDE_CYCLES, 50, cycles a mismatched pair stays revealed before it is hidden.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- select  in  1  select button level; acted on at its rising edge only.
- cursor  in  4  index (0..15) of the currently highlighted cell.
- board  in  N_CELLS*VAL_W  card values; cell i is board[VAL_W*i +: VAL_W].
- revealed  out  16  cells currently face-up (picked or matched).
- matched  out  16  cells permanently matched.
- attempts  out  8  completed pair comparisons, saturating at 255.
- pairs  out  4  matched pairs found, 0..8.
- mismatch  out  1  high while a mismatched pair is displayed.
- game_over  out  1  high once all 8 pairs are matched.

Behaviour:
- Reset: while rst=1 at a clock edge, all outputs go to 0, state goes to PICK1, and the internal select_q register and timer are cleared.
  - Reset has priority over every other event in any state, including mid-countdown.
- Edge detect: sel_edge = select & ~select_q, with select_q registered every cycle.
  - Holding select high yields exactly one pick.
- Valid pick: sel_edge=1, and cursor is not already set in revealed or matched.
  - Invalid picks are ignored and change no state.
- State PICK1, valid pick at edge t:
  - revealed[cursor] is set visible at t+1.
  - first_idx is latched.
  - Go to PICK2.
- State PICK2, valid pick at edge t:
  - revealed[cursor] is set visible at t+1.
  - second_idx is latched.
  - Go to COMPARE.
  - Picking the same cell as first_idx is invalid, because that cell is already revealed.
- State COMPARE (one cycle); results are visible at t+2:
  - attempts increments, saturating at 255.
  - Values equal: matched[first]=matched[second]=1, pairs increments. Go to DONE if the new pairs value is 8, otherwise go to PICK1.
  - Values differ: mismatch=1, timer loads HIDE_CYCLES-1, go to SHOW.
- State SHOW:
  - The timer decrements each cycle, and select edges are ignored (select_q is still updated).
  - When the timer reaches 0, the next edge clears revealed[first] and revealed[second], clears mismatch, and goes to PICK1.
  - mismatch is therefore high for exactly HIDE_CYCLES cycles.
- State DONE: game_over=1 and all selects are ignored until rst.
- revealed always includes matched: matched bits are never cleared except by rst.
- The board is sampled only in COMPARE. Changes to the board between picks have no effect on already-latched indices.
- Cursor changes on the same cycle as a select edge: the cursor value sampled at that edge is the one used.
- Width rules:
  - pairs is 4 bits and never exceeds 8.
  - attempts holds at 255 and does not wrap.
  - A cursor value of N_CELLS or higher is treated as an invalid pick.

Test Plan:
- Reset/idle: assert rst for 2 cycles, then hold select=0 for 20 cycles -> all outputs remain 0 and state is PICK1.
- Match: board cell i = i mod 8; select cursor=2, then cursor=10 (each select high 1 cycle, separated by 3 cycles).
  - -> matched=0x0404, revealed=0x0404, pairs=1, attempts=1, mismatch=0.
- Mismatch/hide, with HIDE_CYCLES=5: pick cursor=0, then cursor=1.
  - -> mismatch=1 for exactly 5 cycles, revealed=0x0003 during that window, then revealed=0x0000, attempts=1.
  - A select pulse during the window is ignored.
- Invalid picks:
  - Hold select high for 10 cycles on cursor=3 -> only bit 3 is revealed.
  - Re-select cursor=3 -> no change.
  - Select a matched cell -> no change, and attempts is unchanged.
- Full game: match pairs (0,8),(1,9)…(7,15) -> pairs=8, matched=0xFFFF, game_over=1, attempts=8.
  - A further select -> no change.
- Reset mid-SHOW: during the mismatch window, assert rst for 1 cycle -> the next cycle shows all outputs 0, and the following pick behaves as a fresh game.
